// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - pipelined radix-2 DIT butterfly with twiddle multiply; BFLY_SAT_EN selects saturating narrowing (default wraps)
module butterfly_pipe #(
    parameter int WIDTH    = 32,
    parameter int TW_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    x0_re,
    input  logic signed [WIDTH-1:0]    x0_im,
    input  logic signed [WIDTH-1:0]    x1_re,
    input  logic signed [WIDTH-1:0]    x1_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  logic                       scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    y0_re,
    output logic signed [WIDTH-1:0]    y0_im,
    output logic signed [WIDTH-1:0]    y1_re,
    output logic signed [WIDTH-1:0]    y1_im,
    output logic                       ovf,
    output logic                       ovf_sticky,
    input  logic                       ovf_clr
);
    localparam int PW  = WIDTH + TW_WIDTH;
    localparam int PW1 = PW + 1;
    localparam int TWD = WIDTH + 2;
    localparam int SW  = WIDTH + 3;
    localparam logic signed [PW1-1:0] RND = PW1'(1) << (TW_WIDTH - 2);

    // Whole pipe moves as one; the output register is the only thing that can block it.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operands widened before multiplying so products keep full precision.
    logic signed [PW-1:0] ex1_re, ex1_im, ew_re, ew_im;
    assign ex1_re = PW'(x1_re);
    assign ex1_im = PW'(x1_im);
    assign ew_re  = PW'(w_re);
    assign ew_im  = PW'(w_im);

    logic                    v1, s1_scale;
    logic signed [WIDTH-1:0] s1_x0_re, s1_x0_im;
    logic signed [PW-1:0]    s1_rr, s1_ii, s1_ri, s1_ir;

    // Stage 1 valid bit; bubbles advance like data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
        end
    end

    // Stage 1 data: x0, scale flag and the four raw partial products.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_x0_re <= x0_re;
            s1_x0_im <= x0_im;
            s1_scale <= scale;
            s1_rr    <= ex1_re * ew_re;
            s1_ii    <= ex1_im * ew_im;
            s1_ri    <= ex1_re * ew_im;
            s1_ir    <= ex1_im * ew_re;
        end
    end

    // Complex product, then round half up back to data scale.
    logic signed [PW1-1:0] p_re, p_im;
    logic signed [TWD-1:0] t_re, t_im;
    always_comb begin
        p_re = PW1'(s1_rr) - PW1'(s1_ii);
        p_im = PW1'(s1_ri) + PW1'(s1_ir);
        t_re = TWD'((p_re + RND) >>> (TW_WIDTH - 1));
        t_im = TWD'((p_im + RND) >>> (TW_WIDTH - 1));
    end

    logic                    v2, s2_scale;
    logic signed [WIDTH-1:0] s2_x0_re, s2_x0_im;
    logic signed [TWD-1:0]   s2_t_re, s2_t_im;

    // Stage 2 valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2 <= v1;
        end
    end

    // Stage 2 data: rounded twiddle product alongside x0 and scale.
    always_ff @(posedge clk) begin
        if (en) begin
            s2_x0_re <= s1_x0_re;
            s2_x0_im <= s1_x0_im;
            s2_scale <= s1_scale;
            s2_t_re  <= t_re;
            s2_t_im  <= t_im;
        end
    end

    // Optional halving with rounding (add one, arithmetic shift).
    function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] v, input logic sc);
        logic signed [SW-1:0] r;
        r    = v + SW'(1);
        half = sc ? (r >>> 1) : v;
    endfunction

    // Narrow to WIDTH bits; returns {overflow, value}.
    function automatic logic [WIDTH:0] narrow(input logic signed [SW-1:0] v);
        logic fits;
        fits = (&v[SW-1:WIDTH-1]) || !(|v[SW-1:WIDTH-1]);
`ifdef BFLY_SAT_EN
        if (!fits) begin
            narrow = {1'b1, v[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}};
        end else begin
            narrow = {1'b0, v[WIDTH-1:0]};
        end
`else
        narrow = {!fits, v[WIDTH-1:0]};
`endif
    endfunction

    // Sum/difference with headroom, optional scaling, then narrowing.
    logic signed [SW-1:0] s_re, s_im, d_re, d_im;
    logic [WIDTH:0]       n_s_re, n_s_im, n_d_re, n_d_im;
    always_comb begin
        s_re   = half(SW'(s2_x0_re) + SW'(s2_t_re), s2_scale);
        s_im   = half(SW'(s2_x0_im) + SW'(s2_t_im), s2_scale);
        d_re   = half(SW'(s2_x0_re) - SW'(s2_t_re), s2_scale);
        d_im   = half(SW'(s2_x0_im) - SW'(s2_t_im), s2_scale);
        n_s_re = narrow(s_re);
        n_s_im = narrow(s_im);
        n_d_re = narrow(d_re);
        n_d_im = narrow(d_im);
    end

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y0_re     <= '0;
            y0_im     <= '0;
            y1_re     <= '0;
            y1_im     <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            y0_re     <= n_s_re[WIDTH-1:0];
            y0_im     <= n_s_im[WIDTH-1:0];
            y1_re     <= n_d_re[WIDTH-1:0];
            y1_im     <= n_d_im[WIDTH-1:0];
            ovf       <= n_s_re[WIDTH] | n_s_im[WIDTH] | n_d_re[WIDTH] | n_d_im[WIDTH];
        end
    end

    // Sticky overflow: set by an overflowing output transfer, which beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - directed self-checking bench for butterfly_pipe (WIDTH=16, TW_WIDTH=16)
module tb_butterfly_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_sticky, ovf_clr;
    logic signed [15:0] x0_re, x0_im, x1_re, x1_im, w_re, w_im;
    logic signed [15:0] y0_re, y0_im, y1_re, y1_im;
    int checks = 0;
    int failures = 0;

`ifdef BFLY_SAT_EN
    localparam logic signed [15:0] OVF_Y0 = 16'sd32767;
`else
    localparam logic signed [15:0] OVF_Y0 = -16'sd3;
`endif

    butterfly_pipe #(.WIDTH(16), .TW_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .w_re(w_re), .w_im(w_im), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Send one transaction and wait (bounded) for its result; lat counts edges from transfer.
    task automatic run_one(input logic signed [15:0] a_re, a_im, b_re, b_im, c_re, c_im,
                           input logic sc,
                           output logic signed [15:0] r0_re, r0_im, r1_re, r1_im,
                           output logic r_ovf, output int lat);
        @(negedge clk);
        x0_re = a_re; x0_im = a_im; x1_re = b_re; x1_im = b_im;
        w_re = c_re; w_im = c_im; scale = sc; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r0_re = y0_re; r0_im = y0_im; r1_re = y1_re; r1_im = y1_im; r_ovf = ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; scale = 1'b0;
        x0_re = 0; x0_im = 0; x1_re = 0; x1_im = 0; w_re = 0; w_im = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", ovf); end
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%0d exp=0", ovf_sticky); end
        checks++; if (y0_re !== 16'sd0 || y1_im !== 16'sd0) begin failures++; $display("FAIL reset_y got=%0d/%0d exp=0/0", y0_re, y1_im); end
    endtask

    task automatic test_basic;
        logic signed [15:0] a, b, c, d;
        logic o;
        int lat;
        run_one(16'sd1000, 16'sd0, 16'sd500, 16'sd0, 16'sd32767, 16'sd0, 1'b0, a, b, c, d, o, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (a !== 16'sd1500) begin failures++; $display("FAIL basic_y0_re got=%0d exp=1500", a); end
        checks++; if (b !== 16'sd0) begin failures++; $display("FAIL basic_y0_im got=%0d exp=0", b); end
        checks++; if (c !== 16'sd500) begin failures++; $display("FAIL basic_y1_re got=%0d exp=500", c); end
        checks++; if (d !== 16'sd0) begin failures++; $display("FAIL basic_y1_im got=%0d exp=0", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0d exp=0", o); end
    endtask

    task automatic test_neg_j_twiddle;
        logic signed [15:0] a, b, c, d;
        logic o;
        int lat;
        run_one(16'sd0, 16'sd0, 16'sd100, 16'sd200, 16'sd0, 16'sh8000, 1'b0, a, b, c, d, o, lat);
        checks++; if (a !== 16'sd200) begin failures++; $display("FAIL negj_y0_re got=%0d exp=200", a); end
        checks++; if (b !== -16'sd100) begin failures++; $display("FAIL negj_y0_im got=%0d exp=-100", b); end
        checks++; if (c !== -16'sd200) begin failures++; $display("FAIL negj_y1_re got=%0d exp=-200", c); end
        checks++; if (d !== 16'sd100) begin failures++; $display("FAIL negj_y1_im got=%0d exp=100", d); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL negj_ovf got=%0d exp=0", o); end
    endtask

    task automatic test_overflow;
        logic signed [15:0] a, b, c, d;
        logic o;
        int lat;
        run_one(16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 1'b0, a, b, c, d, o, lat);
        checks++; if (a !== OVF_Y0) begin failures++; $display("FAIL ovf_y0_re got=%0d exp=%0d", a, OVF_Y0); end
        checks++; if (c !== 16'sd1) begin failures++; $display("FAIL ovf_y1_re got=%0d exp=1", c); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0d exp=1", o); end
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_sticky_early got=%0d exp=0", ovf_sticky); end
        @(negedge clk);
        checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_sticky_set got=%0d exp=1", ovf_sticky); end
        run_one(16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 1'b1, a, b, c, d, o, lat);
        checks++; if (a !== 16'sd32767) begin failures++; $display("FAIL scaled_y0_re got=%0d exp=32767", a); end
        checks++; if (b !== 16'sd0) begin failures++; $display("FAIL scaled_y0_im got=%0d exp=0", b); end
        checks++; if (c !== 16'sd1) begin failures++; $display("FAIL scaled_y1_re got=%0d exp=1", c); end
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL scaled_ovf got=%0d exp=0", o); end
    endtask

    // Transaction k: x0=(100k,k), x1=(k,0), w=(32767,0) -> y0=(101k,k), y1=(99k,k).
    task automatic test_back_to_back;
        int sent = 0;
        int rcv = 0;
        int stall_cnt = 0;
        int cyc = 0;
        bit stall_done = 0;
        bit held_ok = 0;
        logic signed [15:0] held = 0;
        w_re = 16'sd32767; w_im = 16'sd0; scale = 1'b0;
        while (rcv < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!stall_done && sent >= 3 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                if (stall_cnt == 5) stall_done = 1;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0d exp=0", in_ready); end
                if (held_ok) begin
                    checks++; if (y0_re !== held) begin failures++; $display("FAIL stall_hold got=%0d exp=%0d", y0_re, held); end
                end
                held = y0_re;
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (out_valid && out_ready) begin
                checks++; if (y0_re !== 16'(101 * (rcv + 1))) begin failures++; $display("FAIL b2b_y0_re idx=%0d got=%0d exp=%0d", rcv, y0_re, 101 * (rcv + 1)); end
                checks++; if (y1_re !== 16'(99 * (rcv + 1))) begin failures++; $display("FAIL b2b_y1_re idx=%0d got=%0d exp=%0d", rcv, y1_re, 99 * (rcv + 1)); end
                checks++; if (y0_im !== 16'(rcv + 1) || y1_im !== 16'(rcv + 1)) begin failures++; $display("FAIL b2b_im idx=%0d got=%0d/%0d exp=%0d", rcv, y0_im, y1_im, rcv + 1); end
                rcv++;
            end
            if (sent < 8) begin
                in_valid = 1'b1;
                x0_re = 16'(100 * (sent + 1)); x0_im = 16'(sent + 1);
                x1_re = 16'(sent + 1); x1_im = 16'sd0;
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=5", stall_cnt); end
        checks++; if (rcv !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rcv); end
        repeat (4) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_duplicate got=%0d exp=0", out_valid); end
        end
    endtask

    task automatic test_reset_inflight;
        logic signed [15:0] a, b, c, d;
        logic o;
        int lat;
        run_one(16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 1'b0, a, b, c, d, o, lat);
        @(negedge clk);
        checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL rstf_sticky_pre got=%0d exp=1", ovf_sticky); end
        x0_re = 16'sd10; x0_im = 16'sd0; x1_re = 16'sd5; x1_im = 16'sd0;
        w_re = 16'sd32767; w_im = 16'sd0; scale = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        x0_re = 16'sd20;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstf_out_valid got=%0d exp=0", out_valid); end
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL rstf_sticky got=%0d exp=0", ovf_sticky); end
        repeat (6) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstf_spurious got=%0d exp=0", out_valid); end
        end
    endtask

    task automatic test_sticky_clear;
        logic signed [15:0] a, b, c, d;
        logic o;
        int lat;
        run_one(16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, 1'b0, a, b, c, d, o, lat);
        checks++; if (o !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL clr_pre got=%0d/%0d exp=1/1", o, out_valid); end
        ovf_clr = 1'b1;
        @(negedge clk);
        checks++; if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%0d exp=1", ovf_sticky); end
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL clr_clears got=%0d exp=0", ovf_sticky); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_j_twiddle();
        test_overflow();
        test_back_to_back();
        test_reset_inflight();
        test_sticky_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined, parametrised radix-2 decimation-in-time butterfly with twiddle multiply, for the FFT datapath of the ANC signal chain. Each accepted transaction computes y0 = x0 + W·x1 and y1 = x0 − W·x1 on complex operands.
- Optional per-transaction divide-by-2 scaling.
- Per-output and sticky overflow reporting.
- valid/ready flow control on both sides, so FFT stage controllers can stall it.

## Interface
Parameters:
- WIDTH, 32: data width of each real/imag component, signed two's complement.
- TW_WIDTH, 16: twiddle component width, signed Q1.(TW_WIDTH−1); TW_WIDTH ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- x0_re, x0_im, x1_re, x1_im  in  WIDTH each  operands.
- w_re, w_im  in  TW_WIDTH each  twiddle.
- scale  in  1  1 = divide both results by 2, with rounding.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts output.
- y0_re, y0_im, y1_re, y1_im  out  WIDTH each  results.
- ovf  out  1  overflow occurred in any of the four outputs of the current output transaction.
- ovf_sticky  out  1  latched overflow since last clear.
- ovf_clr  in  1  clears ovf_sticky.

## Operation
- Three register stages with one global advance enable: en = !out_valid || out_ready.
- in_ready = en. This is combinational and is the only combinational path from out_ready to in_ready.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Each stage carries a valid bit. Bubbles are not collapsed: a bubble advances like data.
- S1: register x0, scale, and the four raw products x1_re·w_re, x1_im·w_im, x1_re·w_im, x1_im·w_re. Each product is WIDTH+TW_WIDTH bits.
- S2: form the complex product t:
  - p_re = x1_re·w_re − x1_im·w_im and p_im = x1_re·w_im + x1_im·w_re, each WIDTH+TW_WIDTH+1 bits.
  - t = (p + 2^(TW_WIDTH−2)) >>> (TW_WIDTH−1), i.e. round half up, kept at WIDTH+2 bits.
  - Register t, x0 and scale.
- S3: compute s = x0 + t and d = x0 − t at WIDTH+3 bits.
  - If scale = 1: s = (s + 1) >>> 1 and d = (d + 1) >>> 1.
  - Narrow each component to WIDTH bits. A component overflows when its value is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Narrowing mode is set by Configuration: saturate or wrap.
  - Register y0 = s, y1 = d, ovf = OR of the four component overflow flags, and out_valid.
- Twiddle −1.0 (w = −2^(TW_WIDTH−1)) is legal and exact. +1.0 is not representable; use 2^(TW_WIDTH−1)−1.
- ovf_sticky is set in the cycle after an output transfer with ovf = 1 (registered). It is cleared by ovf_clr. If set and clear coincide, set wins.

## Timing
- Reset values: out_valid=0, all stage valid bits 0, y*=0, ovf=0, ovf_sticky=0. in_ready=1 after reset, since out_valid=0.
- Latency: 3 cycles from input transfer to out_valid, with no stalls. Throughput is 1 transaction per cycle.
- Stall: while out_valid && !out_ready, all stages and outputs hold and in_ready=0. No data is lost or duplicated.
- out_valid/y*/ovf are stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight transactions are discarded and no out_valid appears afterward. ovf_sticky is cleared.
- Inputs are sampled only on input transfer. Operand values while in_ready=0 are don't-care.

## Configuration
- BFLY_SAT_EN defined: overflowing components clamp to 2^(WIDTH−1)−1 or −2^(WIDTH−1).
- BFLY_SAT_EN undefined: components wrap, i.e. the low WIDTH bits are kept.
- In both modes ovf and ovf_sticky report overflow identically.

## Test plan
All scenarios use WIDTH=16, TW_WIDTH=16.
- x0=(1000,0), x1=(500,0), w=(32767,0), scale=0 -> after 3 cycles y0=(1500,0), y1=(500,0), ovf=0.
- x0=(0,0), x1=(100,200), w=(0,−32768) (−j), scale=0 -> y0=(200,−100), y1=(−200,100). Checks exact −1.0 twiddle.
- x0=(32767,0), x1=(32767,0), w=(32767,0), scale=0 -> results:
  - With BFLY_SAT_EN: y0_re=32767, y1_re=1, ovf=1, ovf_sticky=1 on the next cycle.
  - Without BFLY_SAT_EN: y0_re=−3, ovf=1.
  - Same operands with scale=1: y0_re=32767, y1_re=1, ovf=0.
- Back-to-back stream of 8 transactions with out_ready held 0 for 5 cycles once 3 are in flight -> in_ready=0 and outputs hold during the stall. All 8 results emerge in order with no loss or duplication.
- Assert rst for 1 cycle with 2 transactions in flight and ovf_sticky=1 -> next cycle out_valid=0, ovf_sticky=0, and no spurious output appears. Also drive ovf_clr and a new overflow transfer in the same cycle -> ovf_sticky stays 1.
